// File: rtl/avl_mem_responder.sv
// Avalon-MM memory responder: byte-enabled burst writes into a local array and
// queued fixed-latency burst reads delivered as gap-free beats.
module avl_mem_responder #(
  parameter int AVL_ADDR       = 30,
  parameter int AVL_SIZE       = 3,
  parameter int AVL_DATA_WIDTH = 256,
  parameter int AVL_BE         = 32,
  parameter int MEM_DEPTH_BITS = 10,
  parameter int READ_LATENCY   = 4,
  parameter int RQ_DEPTH_BITS  = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  output logic                      avl_ready,
  input  logic [AVL_ADDR-1:0]       avl_addr,
  input  logic [AVL_SIZE-1:0]       avl_size,
  input  logic [AVL_DATA_WIDTH-1:0] avl_wdata,
  input  logic [AVL_BE-1:0]         avl_be,
  input  logic                      avl_write_req,
  input  logic                      avl_read_req,
  input  logic                      avl_burstbegin,
  output logic [AVL_DATA_WIDTH-1:0] avl_rdata,
  output logic                      avl_rdata_valid,
  output logic                      protocol_err
);

  localparam int MEM_DEPTH = 1 << MEM_DEPTH_BITS;
  localparam int RQ_DEPTH  = 1 << RQ_DEPTH_BITS;
  localparam int RQ_CNT_W  = RQ_DEPTH_BITS + 1;
  localparam int LAT_W     = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam logic [LAT_W-1:0]         LAT_LOAD = LAT_W'(READ_LATENCY - 1);
  localparam logic [AVL_SIZE-1:0]      SZ_ONE   = AVL_SIZE'(1);
  localparam logic [RQ_CNT_W-1:0]      CNT_ONE  = RQ_CNT_W'(1);
  localparam logic [RQ_DEPTH_BITS-1:0] PTR_ONE  = RQ_DEPTH_BITS'(1);

  typedef enum logic { W_IDLE, W_BURST } wstate_t;
  typedef enum logic [1:0] { R_IDLE, R_WAIT, R_DATA } rstate_t;

  function automatic logic [AVL_DATA_WIDTH-1:0] merge_be(
    input logic [AVL_DATA_WIDTH-1:0] old_w,
    input logic [AVL_DATA_WIDTH-1:0] new_w,
    input logic [AVL_BE-1:0]         be
  );
    logic [AVL_DATA_WIDTH-1:0] res;
    res = old_w;
    for (int i = 0; i < AVL_BE; i++)
      if (be[i]) res[8*i +: 8] = new_w[8*i +: 8];
    return res;
  endfunction

  logic [AVL_DATA_WIDTH-1:0] mem    [MEM_DEPTH];
  logic [MEM_DEPTH_BITS-1:0] rq_idx [RQ_DEPTH];
  logic [AVL_SIZE-1:0]       rq_len [RQ_DEPTH];

  wstate_t                   w_state_q, w_state_d;
  logic [MEM_DEPTH_BITS-1:0] w_base_q, w_base_d;
  logic [AVL_SIZE-1:0]       w_len_q, w_len_d, w_beat_q, w_beat_d;
  rstate_t                   r_state_q, r_state_d;
  logic [LAT_W-1:0]          lat_q, lat_d;
  logic [AVL_SIZE-1:0]       r_beat_q, r_beat_d;
  logic                      rvalid_q, rvalid_d;
  logic [AVL_DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [RQ_DEPTH_BITS-1:0]  rq_wp_q, rq_rp_q;
  logic [RQ_CNT_W-1:0]       rq_cnt_q;
  logic                      rdy_en_q, err_q;

  logic [AVL_SIZE-1:0]       req_len;
  logic                      rq_full, wr_acc, rd_acc, rd_bad, pop;
  logic [MEM_DEPTH_BITS-1:0] wr_idx, rd_idx;
  logic [AVL_DATA_WIDTH-1:0] beat_data;
  logic                      addr_hi_unused;

  assign addr_hi_unused = ^avl_addr[AVL_ADDR-1:MEM_DEPTH_BITS];

  assign req_len   = (avl_size == '0) ? SZ_ONE : avl_size;
  assign rq_full   = (rq_cnt_q == RQ_CNT_W'(RQ_DEPTH));
  assign avl_ready = ~reset & rdy_en_q & ~rq_full;
  assign wr_acc    = avl_write_req & avl_ready;
  assign rd_bad    = avl_read_req & (avl_write_req | (w_state_q == W_BURST));
  assign rd_acc    = avl_read_req & avl_ready & ~rd_bad;
  assign wr_idx    = (w_state_q == W_BURST) ? w_base_q + MEM_DEPTH_BITS'(w_beat_q)
                                            : avl_addr[MEM_DEPTH_BITS-1:0];
  assign rd_idx    = rq_idx[rq_rp_q] + MEM_DEPTH_BITS'(r_beat_q);
  // A write landing in the same cycle as a read beat is forwarded so the beat sees it.
  assign beat_data = (wr_acc && (wr_idx == rd_idx)) ? merge_be(mem[rd_idx], avl_wdata, avl_be)
                                                    : mem[rd_idx];

  assign avl_rdata       = rdata_q;
  assign avl_rdata_valid = rvalid_q;
  assign protocol_err    = err_q;

  always_comb begin
    w_state_d = w_state_q;
    w_base_d  = w_base_q;
    w_len_d   = w_len_q;
    w_beat_d  = w_beat_q;
    case (w_state_q)
      W_IDLE: begin
        if (wr_acc && avl_burstbegin && (req_len > SZ_ONE)) begin
          w_state_d = W_BURST;
          w_base_d  = avl_addr[MEM_DEPTH_BITS-1:0];
          w_len_d   = req_len;
          w_beat_d  = SZ_ONE;
        end
      end
      W_BURST: begin
        if (wr_acc) begin
          if (w_beat_q == w_len_q - SZ_ONE) w_state_d = W_IDLE;
          else                              w_beat_d  = w_beat_q + SZ_ONE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    r_state_d = r_state_q;
    lat_d     = lat_q;
    r_beat_d  = r_beat_q;
    rvalid_d  = 1'b0;
    rdata_d   = rdata_q;
    pop       = 1'b0;
    case (r_state_q)
      R_IDLE: begin
        if (rq_cnt_q != '0) begin
          r_state_d = R_WAIT;
          lat_d     = LAT_LOAD;
        end
      end
      R_WAIT: begin
        if (lat_q == '0) begin
          r_state_d = R_DATA;
          rvalid_d  = 1'b1;
          rdata_d   = beat_data;
          r_beat_d  = SZ_ONE;
        end else begin
          lat_d = lat_q - LAT_W'(1);
        end
      end
      R_DATA: begin
        if (r_beat_q == rq_len[rq_rp_q]) begin
          pop      = 1'b1;
          r_beat_d = '0;
          if (rq_cnt_q > CNT_ONE) begin
            r_state_d = R_WAIT;
            lat_d     = LAT_LOAD;
          end else begin
            r_state_d = R_IDLE;
          end
        end else begin
          rvalid_d = 1'b1;
          rdata_d  = beat_data;
          r_beat_d = r_beat_q + SZ_ONE;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      w_state_q <= W_IDLE;
      w_base_q  <= '0;
      w_len_q   <= '0;
      w_beat_q  <= '0;
      r_state_q <= R_IDLE;
      lat_q     <= '0;
      r_beat_q  <= '0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rq_wp_q   <= '0;
      rq_rp_q   <= '0;
      rq_cnt_q  <= '0;
      rdy_en_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      w_state_q <= w_state_d;
      w_base_q  <= w_base_d;
      w_len_q   <= w_len_d;
      w_beat_q  <= w_beat_d;
      r_state_q <= r_state_d;
      lat_q     <= lat_d;
      r_beat_q  <= r_beat_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rdy_en_q  <= 1'b1;
      if (rd_bad) err_q <= 1'b1;
      if (rd_acc) rq_wp_q <= rq_wp_q + PTR_ONE;
      if (pop)    rq_rp_q <= rq_rp_q + PTR_ONE;
      case ({rd_acc, pop})
        2'b10:   rq_cnt_q <= rq_cnt_q + CNT_ONE;
        2'b01:   rq_cnt_q <= rq_cnt_q - CNT_ONE;
        default: rq_cnt_q <= rq_cnt_q;
      endcase
    end
  end

  // Array and queue payload are plain storage; only pointers and counters are reset.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_idx] <= merge_be(mem[wr_idx], avl_wdata, avl_be);
    if (rd_acc) begin
      rq_idx[rq_wp_q] <= avl_addr[MEM_DEPTH_BITS-1:0];
      rq_len[rq_wp_q] <= req_len;
    end
  end

endmodule
